macro_wb_gpio: RTL and testbench

- Wishbone classic responder instantiated inside each of the four chip macros.
- Terminates the per-macro bus the pad-multiplexing block fans out: wb_clk_i_N, wbs_*_i_N, wbs_ack_o_N, wbs_dat_o_N.
- Exposes memory-mapped registers that drive the macro's north/west/east pad outputs and output enables.
- Samples the buffered pad inputs through synchronizers and captures rising edges in sticky, write-1-to-clear status registers.

---
 rtl/macro_wb_gpio_pkg.sv | 36 +++
 rtl/macro_wb_gpio_sync_edge.sv | 30 +++
 rtl/macro_wb_gpio.sv | 143 ++++++++++++++
 tb/tb_macro_wb_gpio.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/macro_wb_gpio_pkg.sv
// Shared constants for the per-macro Wishbone GPIO responder: register map,
// ID signature, default window base, pad bus widths and byte-lane helpers.
package macro_wb_gpio_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADR = 32'h3000_0000;
   localparam logic [23:0] ID_CONST         = 24'h4D5043;
   localparam int unsigned NORTH_W_DEF      = 10;
   localparam int unsigned SIDE_W_DEF       = 14;

   // Word offsets, i.e. wbs_adr_i[7:2]
   localparam logic [5:0] OFS_ID         = 6'h00;
   localparam logic [5:0] OFS_NORTH_OUT  = 6'h01;
   localparam logic [5:0] OFS_NORTH_OE   = 6'h02;
   localparam logic [5:0] OFS_WEST_OUT   = 6'h03;
   localparam logic [5:0] OFS_WEST_OE    = 6'h04;
   localparam logic [5:0] OFS_EAST_OUT   = 6'h05;
   localparam logic [5:0] OFS_EAST_OE    = 6'h06;
   localparam logic [5:0] OFS_NORTH_IN   = 6'h07;
   localparam logic [5:0] OFS_WEST_IN    = 6'h08;
   localparam logic [5:0] OFS_EAST_IN    = 6'h09;
   localparam logic [5:0] OFS_NORTH_EDGE = 6'h0A;
   localparam logic [5:0] OFS_WEST_EDGE  = 6'h0B;
   localparam logic [5:0] OFS_EAST_EDGE  = 6'h0C;
   localparam logic [5:0] OFS_SCRATCH    = 6'h0D;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      return (old_val & ~lane_mask(sel)) | (new_val & lane_mask(sel));
   endfunction

endpackage

// File: rtl/macro_wb_gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pad inputs plus a previous-value
// flop so a 0->1 transition of the synchronized value is flagged for one cycle.
module gpio_sync_edge #(
   parameter int unsigned W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] pad,
   output logic [W-1:0] sync,
   output logic [W-1:0] rise
);

   logic [W-1:0] meta;
   logic [W-1:0] prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= pad;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;

endmodule

// File: rtl/macro_wb_gpio.sv
// Wishbone classic responder owning one macro's pad outputs/enables, with
// synchronized pad inputs and sticky write-1-to-clear rising-edge flags.
module macro_wb_gpio
   import macro_wb_gpio_pkg::*;
#(
   parameter int unsigned MACRO_ID = 0,
   parameter logic [31:0] BASE_ADR = DEFAULT_BASE_ADR,
   parameter int unsigned NORTH_W  = NORTH_W_DEF,
   parameter int unsigned SIDE_W   = SIDE_W_DEF
)(
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_dat_i,
   input  logic [31:0]        wbs_adr_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic [NORTH_W-1:0] north_o,
   output logic [NORTH_W-1:0] north_oe,
   output logic [SIDE_W-1:0]  west_o,
   output logic [SIDE_W-1:0]  west_oe,
   output logic [SIDE_W-1:0]  east_o,
   output logic [SIDE_W-1:0]  east_oe,
   input  logic [NORTH_W-1:0] north_i,
   input  logic [SIDE_W-1:0]  west_i,
   input  logic [SIDE_W-1:0]  east_i
);

   logic               hit;
   logic               accept;
   logic               wr_en;
   logic [5:0]         word;
   logic [31:0]        wmask;
   logic [31:0]        rdata;
   logic [31:0]        scratch;
   logic [1:0]         unused_adr;
   logic [NORTH_W-1:0] north_sync, north_rise, north_edge, north_clr;
   logic [SIDE_W-1:0]  west_sync,  west_rise,  west_edge,  west_clr;
   logic [SIDE_W-1:0]  east_sync,  east_rise,  east_edge,  east_clr;

   assign unused_adr = wbs_adr_i[1:0];
   assign hit        = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   // Gating on !ack makes a held strobe alternate ack/idle cycles
   assign accept     = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
   assign wr_en      = accept & wbs_we_i;
   assign word       = wbs_adr_i[7:2];
   assign wmask      = lane_mask(wbs_sel_i);

   gpio_sync_edge #(.W(NORTH_W)) u_north (
      .clk(wb_clk_i), .rst(wb_rst_i), .pad(north_i), .sync(north_sync), .rise(north_rise)
   );
   gpio_sync_edge #(.W(SIDE_W)) u_west (
      .clk(wb_clk_i), .rst(wb_rst_i), .pad(west_i), .sync(west_sync), .rise(west_rise)
   );
   gpio_sync_edge #(.W(SIDE_W)) u_east (
      .clk(wb_clk_i), .rst(wb_rst_i), .pad(east_i), .sync(east_sync), .rise(east_rise)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         north_o  <= '0;
         north_oe <= '0;
         west_o   <= '0;
         west_oe  <= '0;
         east_o   <= '0;
         east_oe  <= '0;
         scratch  <= '0;
      end else if (wr_en) begin
         case (word)
            OFS_NORTH_OUT: north_o  <= NORTH_W'(lane_merge(32'(north_o),  wbs_dat_i, wbs_sel_i));
            OFS_NORTH_OE:  north_oe <= NORTH_W'(lane_merge(32'(north_oe), wbs_dat_i, wbs_sel_i));
            OFS_WEST_OUT:  west_o   <= SIDE_W'(lane_merge(32'(west_o),    wbs_dat_i, wbs_sel_i));
            OFS_WEST_OE:   west_oe  <= SIDE_W'(lane_merge(32'(west_oe),   wbs_dat_i, wbs_sel_i));
            OFS_EAST_OUT:  east_o   <= SIDE_W'(lane_merge(32'(east_o),    wbs_dat_i, wbs_sel_i));
            OFS_EAST_OE:   east_oe  <= SIDE_W'(lane_merge(32'(east_oe),   wbs_dat_i, wbs_sel_i));
            OFS_SCRATCH:   scratch  <= lane_merge(scratch, wbs_dat_i, wbs_sel_i);
            default: ;
         endcase
      end
   end

   always_comb begin
      north_clr = '0;
      west_clr  = '0;
      east_clr  = '0;
      if (wr_en) begin
         case (word)
            OFS_NORTH_EDGE: north_clr = NORTH_W'(wbs_dat_i & wmask);
            OFS_WEST_EDGE:  west_clr  = SIDE_W'(wbs_dat_i & wmask);
            OFS_EAST_EDGE:  east_clr  = SIDE_W'(wbs_dat_i & wmask);
            default: ;
         endcase
      end
   end

   // A new rising edge is ORed in after the clear so it survives a same-cycle W1C
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         north_edge <= '0;
         west_edge  <= '0;
         east_edge  <= '0;
      end else begin
         north_edge <= (north_edge & ~north_clr) | north_rise;
         west_edge  <= (west_edge  & ~west_clr)  | west_rise;
         east_edge  <= (east_edge  & ~east_clr)  | east_rise;
      end
   end

   always_comb begin
      rdata = '0;
      case (word)
         OFS_ID:         rdata = {ID_CONST, 8'(MACRO_ID)};
         OFS_NORTH_OUT:  rdata = 32'(north_o);
         OFS_NORTH_OE:   rdata = 32'(north_oe);
         OFS_WEST_OUT:   rdata = 32'(west_o);
         OFS_WEST_OE:    rdata = 32'(west_oe);
         OFS_EAST_OUT:   rdata = 32'(east_o);
         OFS_EAST_OE:    rdata = 32'(east_oe);
         OFS_NORTH_IN:   rdata = 32'(north_sync);
         OFS_WEST_IN:    rdata = 32'(west_sync);
         OFS_EAST_IN:    rdata = 32'(east_sync);
         OFS_NORTH_EDGE: rdata = 32'(north_edge);
         OFS_WEST_EDGE:  rdata = 32'(west_edge);
         OFS_EAST_EDGE:  rdata = 32'(east_edge);
         OFS_SCRATCH:    rdata = scratch;
         default:        rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= accept;
         wbs_dat_o <= (accept && !wbs_we_i) ? rdata : 32'h0;
      end
   end

endmodule

// File: tb/tb_macro_wb_gpio.sv
// Directed self-checking bench for macro_wb_gpio instantiated as macro 2.
module tb_macro_wb_gpio;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] wdat = 32'h0;
   logic [31:0] adr  = 32'h0;
   logic        ack;
   logic [31:0] dat_o;
   logic [9:0]  north_o, north_oe;
   logic [13:0] west_o, west_oe, east_o, east_oe;
   logic [9:0]  north_i = '0;
   logic [13:0] west_i  = '0;
   logic [13:0] east_i  = '0;

   int checks = 0;
   int errors = 0;

   logic        got;
   logic [31:0] rd;
   int          lat;

   always #5 clk = ~clk;

   macro_wb_gpio #(.MACRO_ID(2)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_dat_i(wdat), .wbs_adr_i(adr),
      .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .north_o(north_o), .north_oe(north_oe),
      .west_o(west_o), .west_oe(west_oe),
      .east_o(east_o), .east_oe(east_oe),
      .north_i(north_i), .west_i(west_i), .east_i(east_i)
   );

   // Single bus transaction; waits up to 10 cycles for ack, returns latency in cycles
   task automatic wb_access(input logic [31:0] a, input logic w, input logic [3:0] s,
                            input logic [31:0] d, output logic g, output logic [31:0] r,
                            output int l);
      @(posedge clk); #1;
      adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
      g = 1'b0; r = 32'h0; l = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            g = 1'b1; r = dat_o; l = i;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ack !== 1'b0 || dat_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_bus: ack=%b dat=%h, want ack=0 dat=0", ack, dat_o);
      end
      checks++;
      if ({north_o, north_oe, west_o, west_oe, east_o, east_oe} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_pads: got %h, want all zero",
                  {north_o, north_oe, west_o, west_oe, east_o, east_oe});
      end
      rst = 1'b0;
   endtask

   task automatic test_id_read();
      wb_access(32'h3000_0000, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (got !== 1'b1 || lat !== 1) begin
         errors++;
         $display("[TB] FAIL id_latency: got ack=%b lat=%0d, want ack=1 lat=1", got, lat);
      end
      checks++;
      if (rd !== 32'h4D50_4302) begin
         errors++;
         $display("[TB] FAIL id_data: got %h, want 4d504302", rd);
      end
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || dat_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL id_after: ack=%b dat=%h, want ack=0 dat=0", ack, dat_o);
      end
   endtask

   task automatic test_byte_lanes();
      wb_access(32'h3000_000C, 1'b1, 4'b0001, 32'h0000_3FFF, got, rd, lat);
      checks++;
      if (got !== 1'b1 || west_o !== 14'h00FF) begin
         errors++;
         $display("[TB] FAIL lane0_write: ack=%b west_o=%h, want ack=1 west_o=00ff", got, west_o);
      end
      wb_access(32'h3000_000C, 1'b1, 4'b0010, 32'h0000_3F00, got, rd, lat);
      checks++;
      if (west_o !== 14'h3FFF) begin
         errors++;
         $display("[TB] FAIL lane1_write: west_o=%h, want 3fff", west_o);
      end
      checks++;
      if (west_oe !== 14'h0 || east_o !== 14'h0 || north_o !== 10'h0) begin
         errors++;
         $display("[TB] FAIL lane_isolation: west_oe=%h east_o=%h north_o=%h, want 0",
                  west_oe, east_o, north_o);
      end
      wb_access(32'h3000_000C, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'h0000_3FFF) begin
         errors++;
         $display("[TB] FAIL west_readback: got %h, want 00003fff", rd);
      end
   endtask

   task automatic test_edge_capture();
      @(posedge clk); #1;
      east_i[5] = 1'b1;
      repeat (3) @(posedge clk);
      wb_access(32'h3000_0024, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'h0000_0020) begin
         errors++;
         $display("[TB] FAIL east_in: got %h, want 00000020", rd);
      end
      wb_access(32'h3000_0030, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'h0000_0020) begin
         errors++;
         $display("[TB] FAIL east_edge_set: got %h, want 00000020", rd);
      end
      wb_access(32'h3000_0030, 1'b1, 4'h1, 32'h0000_0020, got, rd, lat);
      wb_access(32'h3000_0030, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL east_edge_clear: got %h, want 00000000", rd);
      end
      // Fall, then line up the next rise so its set lands on the clear's accept edge
      @(posedge clk); #1;
      east_i[5] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      east_i[5] = 1'b1;
      @(posedge clk);
      wb_access(32'h3000_0030, 1'b1, 4'h1, 32'h0000_0020, got, rd, lat);
      wb_access(32'h3000_0030, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'h0000_0020) begin
         errors++;
         $display("[TB] FAIL set_beats_clear: got %h, want 00000020", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] pattern;
      int         acks;
      logic       data_ok;
      wb_access(32'h3000_0034, 1'b1, 4'hF, 32'hA5A5_5A5A, got, rd, lat);
      pattern = '0;
      acks    = 0;
      data_ok = 1'b1;
      @(posedge clk); #1;
      adr = 32'h3000_0034; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         pattern[5-i] = ack;
         if (ack) begin
            acks++;
            if (dat_o !== 32'hA5A5_5A5A) data_ok = 1'b0;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      checks++;
      if (acks !== 3 || pattern !== 6'b101010) begin
         errors++;
         $display("[TB] FAIL b2b_acks: count=%0d pattern=%b, want 3 and 101010", acks, pattern);
      end
      checks++;
      if (data_ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_data: some ack carried data other than a5a55a5a");
      end
   endtask

   task automatic test_window();
      wb_access(32'h3000_0104, 1'b1, 4'hF, 32'h0000_03FF, got, rd, lat);
      checks++;
      if (got !== 1'b0 || north_o !== 10'h0) begin
         errors++;
         $display("[TB] FAIL out_of_window: ack=%b north_o=%h, want ack=0 north_o=000", got, north_o);
      end
      wb_access(32'h3000_003C, 1'b1, 4'hF, 32'hFFFF_FFFF, got, rd, lat);
      wb_access(32'h3000_003C, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (got !== 1'b1 || rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL unmapped_read: ack=%b dat=%h, want ack=1 dat=0", got, rd);
      end
      wb_access(32'h3000_0034, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'hA5A5_5A5A) begin
         errors++;
         $display("[TB] FAIL scratch_untouched: got %h, want a5a55a5a", rd);
      end
   endtask

   task automatic test_reset_mid();
      wb_access(32'h3000_0008, 1'b1, 4'h3, 32'h0000_03FF, got, rd, lat);
      checks++;
      if (north_oe !== 10'h3FF) begin
         errors++;
         $display("[TB] FAIL north_oe_write: got %h, want 3ff", north_oe);
      end
      east_i = '0;
      repeat (5) @(posedge clk);
      #1;
      adr = 32'h3000_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (ack !== 1'b0 || dat_o !== 32'h0 || north_oe !== 10'h0 || west_o !== 14'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid: ack=%b dat=%h north_oe=%h west_o=%h, want all 0",
                  ack, dat_o, north_oe, west_o);
      end
      for (int r = 0; r < 3; r++) begin
         wb_access(32'h3000_0028 + 32'(4 * r), 1'b0, 4'hF, 32'h0, got, rd, lat);
         checks++;
         if (got !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL edge_after_reset_%0d: ack=%b dat=%h, want ack=1 dat=0", r, got, rd);
         end
      end
      wb_access(32'h3000_0034, 1'b0, 4'hF, 32'h0, got, rd, lat);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("[TB] FAIL scratch_after_reset: got %h, want 00000000", rd);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting macro_wb_gpio bench");
      test_reset();
      test_id_read();
      test_byte_lanes();
      test_edge_capture();
      test_back_to_back();
      test_window();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
